// File: rtl/counter_cmd_sequencer.sv
// counter_cmd_sequencer: drives en/set/up of an up/down counter from LOAD / COUNT / NOP
// commands and reports completion, captured value and overflow. Optional macro: CNT_SEQ_CMD_FIFO_EN.
module counter_cmd_sequencer #(
    parameter int WIDTH       = 8,
    parameter int STEP_W      = 8,
    parameter bit STOP_ON_OVF = 1'b1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             cmd_valid_in,
    output logic             cmd_ready_out,
    input  logic [1:0]       cmd_op_in,
    input  logic [WIDTH-1:0] cmd_data_in,
    output logic             en_ctrl_out,
    output logic             set_ctrl_out,
    output logic             up_ctrl_out,
    output logic [WIDTH-1:0] counter_load_out,
    input  logic [WIDTH-1:0] counter_val_in,
    input  logic             ovf_in,
    output logic             done_out,
    output logic             ovf_flag_out,
    output logic [WIDTH-1:0] result_out
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_UP   = 2'b01;
    localparam logic [1:0] OP_DOWN = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [STEP_W-1:0]   remaining;
    logic                ovf_seen;
    logic                up_dir;
    logic [WIDTH-1:0]    load_val;
    logic [WIDTH-1:0]    result_hold;
    logic                ovf_hold;

    // Command presented to the FSM this cycle (from the port or from the FIFO head).
    logic                go;
    logic [1:0]          go_op;
    logic [WIDTH-1:0]    go_data;
    logic [STEP_W-1:0]   go_steps;
    logic                go_is_count;

    assign go_steps    = go_data[STEP_W-1:0];
    assign go_is_count = (go_op == OP_UP) || (go_op == OP_DOWN);

`ifdef CNT_SEQ_CMD_FIFO_EN
    logic [1:0]       fifo_op   [2];
    logic [WIDTH-1:0] fifo_data [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       fifo_cnt;
    logic             push;
    logic             pop;

    // A full FIFO still accepts when the FSM drains an entry in the same cycle.
    assign pop           = (state == S_IDLE) && (fifo_cnt != 2'd0);
    assign cmd_ready_out = !rst_in && ((fifo_cnt != 2'd2) || pop);
    assign push          = cmd_valid_in && cmd_ready_out;
    assign go            = pop;
    assign go_op         = fifo_op[rd_ptr];
    assign go_data       = fifo_data[rd_ptr];

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_op[wr_ptr]   <= cmd_op_in;
            fifo_data[wr_ptr] <= cmd_data_in;
        end
    end
`else
    assign cmd_ready_out = !rst_in && (state == S_IDLE);
    assign go            = cmd_valid_in && cmd_ready_out;
    assign go_op         = cmd_op_in;
    assign go_data       = cmd_data_in;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        en_ctrl_out      = 1'b0;
        set_ctrl_out     = 1'b0;
        done_out         = 1'b0;
        up_ctrl_out      = up_dir;
        counter_load_out = load_val;
        result_out       = result_hold;
        ovf_flag_out     = ovf_hold;
        case (state)
            S_IDLE: begin
                if (go) begin
                    if (go_op == OP_LOAD) begin
                        state_nxt = S_LOAD;
                    end else if (go_is_count && (go_steps != '0)) begin
                        state_nxt = S_RUN;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                set_ctrl_out = 1'b1;
                state_nxt    = S_DONE;
            end
            S_RUN: begin
                en_ctrl_out = 1'b1;
                // An overflow seen while enabled ends the run right after this cycle.
                if ((STOP_ON_OVF && ovf_in) || (remaining == STEP_W'(1))) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done_out     = 1'b1;
                result_out   = counter_val_in;
                ovf_flag_out = ovf_seen;
                state_nxt    = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            remaining   <= '0;
            ovf_seen    <= 1'b0;
            up_dir      <= 1'b0;
            load_val    <= '0;
            result_hold <= '0;
            ovf_hold    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    ovf_seen <= 1'b0;
                    if (go) begin
                        remaining <= go_steps;
                        if (go_op == OP_LOAD) begin
                            load_val <= go_data;
                        end
                        // Direction only changes when a run will actually start.
                        if (go_is_count && (go_steps != '0)) begin
                            up_dir <= (go_op == OP_UP);
                        end
                    end
                end
                S_RUN: begin
                    remaining <= remaining - STEP_W'(1);
                    if (ovf_in) begin
                        ovf_seen <= 1'b1;
                    end
                end
                S_DONE: begin
                    result_hold <= counter_val_in;
                    ovf_hold    <= ovf_seen;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Directed bench for counter_cmd_sequencer (default build, no command FIFO) with a
// behavioural counter and a command-level expectation model checked every cycle.
module tb_counter_cmd_sequencer;

    localparam int WIDTH  = 8;
    localparam int STEP_W = 6;
    localparam bit STOP   = 1'b1;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             en, set, up;
    logic [WIDTH-1:0] load;
    logic [WIDTH-1:0] cval = '0;
    logic             ovf;
    logic             done;
    logic             ovf_flag;
    logic [WIDTH-1:0] result;

    counter_cmd_sequencer #(.WIDTH(WIDTH), .STEP_W(STEP_W), .STOP_ON_OVF(STOP)) dut (
        .clk_in(clk), .rst_in(rst), .cmd_valid_in(cmd_valid), .cmd_ready_out(cmd_ready),
        .cmd_op_in(cmd_op), .cmd_data_in(cmd_data), .en_ctrl_out(en), .set_ctrl_out(set),
        .up_ctrl_out(up), .counter_load_out(load), .counter_val_in(cval), .ovf_in(ovf),
        .done_out(done), .ovf_flag_out(ovf_flag), .result_out(result)
    );

    always #5 clk = ~clk;

    // Counter being sequenced: ovf flags the enabled cycle that will wrap.
    always @(posedge clk) begin
        if (set)     cval <= load;
        else if (en) cval <= up ? cval + 8'd1 : cval - 8'd1;
    end
    assign ovf = en && (up ? (cval == 8'hFF) : (cval == 8'h00));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Command-level model: cycles of set / enable / done plus the expected counter value.
    int  set_c = -1, run_s = -1, run_e = -1, done_c = -1;
    int  mval = 0, mval_pre = 0, run_v0 = 0;
    bit  run_up = 1'b0;
    int  p_load = 0, p_res = 0;
    bit  p_ovf = 1'b0;
    int  held_res = 0, held_load = 0;
    bit  held_ovf = 1'b0;
    bit  chk_on = 1'b0;
    int  en_cnt = 0, set_cnt = 0;

    task automatic plan(input logic [1:0] op, input logic [7:0] d, input int c);
        int n, ws, k;
        bit dir_up, ov;
        set_c = -1; run_s = -1; run_e = -1;
        mval_pre = mval;
        n = int'(d) % (1 << STEP_W);
        if (op == 2'b00) begin
            set_c = c + 1; done_c = c + 2;
            p_load = int'(d); mval = int'(d); p_res = mval; p_ovf = 1'b0;
        end else if (op == 2'b11 || n == 0) begin
            done_c = c + 1; p_res = mval; p_ovf = 1'b0;
        end else begin
            dir_up = (op == 2'b01);
            ws = dir_up ? 256 - mval : mval + 1;
            ov = (ws <= n);
            k = (ov && STOP) ? ws : n;
            run_s = c + 1; run_e = c + k; done_c = c + k + 1;
            run_v0 = mval; run_up = dir_up;
            mval = dir_up ? (mval + k) & 255 : (mval - k) & 255;
            p_res = mval; p_ovf = ov;
        end
    endtask

    // Called at the falling edge of the last cycle before the reset edge.
    task automatic apply_reset();
        int r;
        r = cyc;
        rst = 1'b1;
        if (run_s > r) begin
            run_s = -1; run_e = -1; mval = mval_pre;
        end else if (run_s >= 0 && r <= run_e) begin
            run_e = r;
            mval = run_up ? (run_v0 + (r - run_s + 1)) & 255 : (run_v0 - (r - run_s + 1)) & 255;
        end
        if (set_c > r) begin
            set_c = -1; mval = mval_pre;
        end
        if (done_c > r) done_c = -1;
    endtask

    always @(negedge clk) begin
        if (en)  en_cnt++;
        if (set) set_cnt++;
    end

    always @(posedge clk) begin
        logic r;
        r = rst;
        #1;
        if (chk_on) begin
            if (r) begin
                held_res = 0; held_ovf = 1'b0; held_load = 0;
            end else if (cyc == done_c) begin
                held_res = p_res; held_ovf = p_ovf;
            end
            if (!r && cyc == set_c) held_load = p_load;
            chk("en", en, (cyc >= run_s) && (cyc <= run_e));
            chk("set", set, cyc == set_c);
            chk("done", done, cyc == done_c);
            chk("ready", cmd_ready, !rst && (cyc > done_c));
            chk("load", load, held_load);
            chk("result", result, held_res);
            chk("ovf_flag", ovf_flag, held_ovf);
            if (cyc >= run_s && cyc <= run_e) chk("up", up, run_up);
        end
    end

    task automatic issue(input logic [1:0] op, input logic [7:0] d, output int acc);
        int b;
        b = 0;
        @(negedge clk);
        while (!cmd_ready && b < 300) begin
            @(negedge clk);
            b++;
        end
        if (!cmd_ready) chk("ready_timeout", cmd_ready, 1);
        cmd_op = op; cmd_data = d; cmd_valid = 1'b1;
        en_cnt = 0; set_cnt = 0;
        acc = cyc;
        plan(op, d, acc);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_cmd(input string nm, input logic [1:0] op, input logic [7:0] d,
                           input int e_lat, input int e_en, input int e_set,
                           input logic [7:0] e_res, input logic e_ovf);
        int acc, b;
        issue(op, d, acc);
        b = 0;
        while (!done && b < 300) begin
            @(posedge clk);
            #1;
            b++;
        end
        chk({nm, "_done_seen"}, done, 1);
        chk({nm, "_latency"}, cyc - acc, e_lat);
        chk({nm, "_en_cycles"}, en_cnt, e_en);
        chk({nm, "_set_cycles"}, set_cnt, e_set);
        chk({nm, "_result"}, result, e_res);
        chk({nm, "_ovf"}, ovf_flag, e_ovf);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = '0;
        @(negedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_load", load, 0);
        chk("rst_up", up, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", cmd_ready, 1);

        run_cmd("load_a5", 2'b00, 8'hA5, 2, 0, 1, 8'hA5, 1'b0);
        run_cmd("load_10", 2'b00, 8'h10, 2, 0, 1, 8'h10, 1'b0);
        run_cmd("up5", 2'b01, 8'd5, 6, 5, 0, 8'h15, 1'b0);
        run_cmd("load_fd", 2'b00, 8'hFD, 2, 0, 1, 8'hFD, 1'b0);
        run_cmd("up6_wrap", 2'b01, 8'd6, STOP ? 4 : 7, STOP ? 3 : 6, 0,
                STOP ? 8'h00 : 8'h03, 1'b1);
        run_cmd("down0", 2'b10, 8'h00, 1, 0, 0, STOP ? 8'h00 : 8'h03, 1'b0);
        run_cmd("nop", 2'b11, 8'h77, 1, 0, 0, STOP ? 8'h00 : 8'h03, 1'b0);
        run_cmd("down_masked0", 2'b10, 8'h40, 1, 0, 0, STOP ? 8'h00 : 8'h03, 1'b0);
        run_cmd("load_20", 2'b00, 8'h20, 2, 0, 1, 8'h20, 1'b0);
        run_cmd("up_masked3", 2'b01, 8'hC3, 4, 3, 0, 8'h23, 1'b0);
        run_cmd("load_01", 2'b00, 8'h01, 2, 0, 1, 8'h01, 1'b0);
        run_cmd("down5_wrap", 2'b10, 8'd5, STOP ? 3 : 6, STOP ? 2 : 5, 0,
                STOP ? 8'hFF : 8'hFC, 1'b1);

        // Reset during a long run: no done, everything cleared, ready once reset drops.
        begin
            int acc;
            run_cmd("load_00", 2'b00, 8'h00, 2, 0, 1, 8'h00, 1'b0);
            issue(2'b01, 8'd20, acc);
            repeat (3) @(negedge clk);
            apply_reset();
            @(posedge clk);
            #1;
            chk("midrst_en", en, 0);
            chk("midrst_done", done, 0);
            chk("midrst_ready", cmd_ready, 0);
            chk("midrst_result", result, 0);
            chk("midrst_ovf", ovf_flag, 0);
            chk("midrst_load", load, 0);
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk);
            #1;
            chk("ready_after_midrst", cmd_ready, 1);
            chk("counter_after_midrst", cval, 8'h03);
        end
        run_cmd("down2", 2'b10, 8'd2, 3, 2, 0, 8'h01, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
